shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_pkg.sv | 19 +
 rtl/shift_seq_ctrl_if.sv | 24 ++
 rtl/shift_bit_timer.sv | 52 +++++
 rtl/shift_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-register sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam logic MODE_TX = 1'b0;
    localparam logic MODE_RX = 1'b1;

    // Even parity bit: makes the total count of ones (word + bit) even.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Parallel/serial signal bundle between the datapath, the sequencer and the pins.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             MODE;
    logic [WIDTH-1:0] PDIN;
    logic             SDIN;
    logic             SDOUT;
    logic [WIDTH-1:0] PDOUT;
    logic             BUSY;
    logic             DONE;
    logic             PERR;

    modport master (
        output START, MODE, PDIN, SDIN,
        input  SDOUT, PDOUT, BUSY, DONE, PERR
    );

    modport slave (
        input  START, MODE, PDIN, SDIN,
        output SDOUT, PDOUT, BUSY, DONE, PERR
    );
endinterface

// File: rtl/shift_bit_timer.sv
// Bit-period and bit-index counters: emits a boundary strobe and a last-bit flag.
module shift_bit_timer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic CLK,
    input  logic CLR,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic last_bit
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

    logic [PW-1:0] period_q, period_d;
    logic [BW-1:0] bit_q, bit_d;

    assign tick     = run && (period_q == PERIOD_LAST);
    assign last_bit = (bit_q == BIT_LAST);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing branch would infer a latch.
        period_d = period_q;
        bit_d    = bit_q;
        if (clear) begin
            period_d = '0;
            bit_d    = '0;
        end else if (run) begin
            period_d = tick ? '0 : period_q + 1'b1;
            if (tick && !last_bit) begin
                bit_d = bit_q + 1'b1;
            end
        end else begin
            period_d = '0;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            period_q <= '0;
            bit_q    <= '0;
        end else begin
            period_q <= period_d;
            bit_q    <= bit_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serial transmit/receive sequencer over a WIDTH-bit shift register, LSB first.
// Build option: define PARITY_EN to append an even-parity bit period.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input logic             CLK,
    input logic             CLR,
    shift_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] pdout_q, pdout_d;
`ifdef PARITY_EN
    logic             tx_par_q, tx_par_d;
    logic             perr_q, perr_d;
`endif

    logic tick;
    logic last_bit;
    logic busy;
    logic accept;

    assign busy   = (state_q == SHIFT) || (state_q == PAR);
    assign accept = (state_q == IDLE) && bus.START;

    shift_bit_timer #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) u_timer (
        .CLK      (CLK),
        .CLR      (CLR),
        .clear    (accept),
        .run      (busy),
        .tick     (tick),
        .last_bit (last_bit)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sr_d    = sr_q;
        pdout_d = pdout_q;
`ifdef PARITY_EN
        tx_par_d = tx_par_q;
        perr_d   = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    state_d = SHIFT;
                    mode_d  = bus.MODE;
                    sr_d    = (bus.MODE == MODE_TX) ? bus.PDIN : '0;
`ifdef PARITY_EN
                    tx_par_d = even_parity(32'(bus.PDIN));
                    perr_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (tick) begin
                    // Receive fills from the top; transmit backfills with idle-high ones.
                    sr_d = {(mode_q == MODE_RX) ? bus.SDIN : 1'b1, sr_q[WIDTH-1:1]};
                    if (last_bit) begin
`ifdef PARITY_EN
                        state_d = PAR;
`else
                        state_d = FIN;
                        if (mode_q == MODE_RX) begin
                            pdout_d = sr_d;
                        end
`endif
                    end
                end
            end
            PAR: begin
`ifdef PARITY_EN
                if (tick) begin
                    state_d = FIN;
                    if (mode_q == MODE_RX) begin
                        pdout_d = sr_q;
                        perr_d  = (bus.SDIN != even_parity(32'(sr_q)));
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            mode_q  <= MODE_TX;
            sr_q    <= '0;
            pdout_q <= '0;
`ifdef PARITY_EN
            tx_par_q <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sr_q    <= sr_d;
            pdout_q <= pdout_d;
`ifdef PARITY_EN
            tx_par_q <= tx_par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    // Line idles high outside the bit periods and during receive.
    always_comb begin
        bus.SDOUT = 1'b1;
        if (mode_q == MODE_TX) begin
            if (state_q == SHIFT) begin
                bus.SDOUT = sr_q[0];
            end
`ifdef PARITY_EN
            if (state_q == PAR) begin
                bus.SDOUT = tx_par_q;
            end
`endif
        end
    end

    assign bus.PDOUT = pdout_q;
    assign bus.BUSY  = busy;
    assign bus.DONE  = (state_q == FIN);
`ifdef PARITY_EN
    assign bus.PERR  = perr_q;
`else
    assign bus.PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: two instances (DIV=1 and DIV=3), random and directed transfers.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    localparam int W  = 8;
    localparam int D0 = 1;
    localparam int D1 = 3;
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        int           lane;
        logic         mode;
        logic [W-1:0] word;
        logic [W-1:0] pdout;
        logic         perr;
        int           start_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   start_v, mode_v, sdin_v, clr_v, clr_prev;
    logic [W-1:0] pdin_v [2];
    logic [1:0]   sdout_w, busy_w, done_w, perr_w;
    logic [W-1:0] pdout_w [2];
    logic [W-1:0] mdl_pdout [2];

    exp_t sb[$];
    logic obs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_seq_ctrl_if #(.WIDTH(W)) bus0 ();
    shift_seq_ctrl_if #(.WIDTH(W)) bus1 ();

    shift_seq_ctrl #(.WIDTH(W), .DIV(D0)) u_dut0 (.CLK(clk), .CLR(clr_v[0]), .bus(bus0));
    shift_seq_ctrl #(.WIDTH(W), .DIV(D1)) u_dut1 (.CLK(clk), .CLR(clr_v[1]), .bus(bus1));

    assign bus0.START = start_v[0];
    assign bus0.MODE  = mode_v[0];
    assign bus0.PDIN  = pdin_v[0];
    assign bus0.SDIN  = sdin_v[0];
    assign bus1.START = start_v[1];
    assign bus1.MODE  = mode_v[1];
    assign bus1.PDIN  = pdin_v[1];
    assign bus1.SDIN  = sdin_v[1];

    assign sdout_w[0] = bus0.SDOUT;
    assign busy_w[0]  = bus0.BUSY;
    assign done_w[0]  = bus0.DONE;
    assign perr_w[0]  = bus0.PERR;
    assign pdout_w[0] = bus0.PDOUT;
    assign sdout_w[1] = bus1.SDOUT;
    assign busy_w[1]  = bus1.BUSY;
    assign done_w[1]  = bus1.DONE;
    assign perr_w[1]  = bus1.PERR;
    assign pdout_w[1] = bus1.PDOUT;

    function automatic int div_of(input int l);
        return (l == 0) ? D0 : D1;
    endfunction

    // Busy cycles of one transfer: data bits plus optional parity bit, each DIV cycles long.
    function automatic int xlen(input int l);
        return (W + PB) * div_of(l);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) clr_prev <= clr_v;

    // Monitor: consumes the scoreboard whenever a DUT raises DONE.
    always @(negedge clk) begin
        exp_t        e;
        int          d, x, j;
        logic [63:0] ov, ev;
        for (int l = 0; l < 2; l++) begin
            if (clr_prev[l] === 1'b1) begin
                check($sformatf("reset_state[%0d]", l),
                      64'({sdout_w[l], pdout_w[l], busy_w[l], done_w[l], perr_w[l]}),
                      64'({1'b1, {W{1'b0}}, 3'b000}));
            end
            if (busy_w[l] === 1'b1) obs.push_back(sdout_w[l]);
            if (done_w[l] === 1'b1) begin
                if (sb.size() == 0 || sb[0].lane != l) begin
                    check($sformatf("unexpected_done[%0d]", l), 64'(done_w[l]), 64'd0);
                end else begin
                    e = sb.pop_front();
                    d = div_of(l);
                    x = xlen(l);
                    check($sformatf("done_cycle[%0d]", l), 64'(cyc), 64'(e.start_cyc + x));
                    check($sformatf("busy_len[%0d]", l), 64'(obs.size()), 64'(x));
                    check($sformatf("pdout[%0d]", l), 64'(pdout_w[l]), 64'(e.pdout));
                    check($sformatf("perr[%0d]", l), 64'(perr_w[l]), 64'(e.perr));
                    if (e.mode == MODE_TX) begin
                        ov = '0;
                        ev = '0;
                        for (int i = 0; i < obs.size() && i < 64; i++) ov[i] = obs[i];
                        for (int i = 0; i < x; i++) begin
                            j = i / d;
                            ev[i] = (j < W) ? e.word[j] : ^e.word;
                        end
                        check($sformatf("tx_bits[%0d]", l), ov, ev);
                    end
                end
                obs.delete();
            end
        end
        if (sb.size() != 0 && cyc > sb[0].start_cyc + xlen(sb[0].lane)) begin
            e = sb.pop_front();
            check($sformatf("done_timeout[%0d]", e.lane), 64'(cyc), 64'(e.start_cyc + xlen(e.lane)));
        end
        if (busy_w !== 2'b11 && busy_w[0] !== 1'b1 && busy_w[1] !== 1'b1 &&
            done_w[0] !== 1'b1 && done_w[1] !== 1'b1) obs.delete();
    end

    // One transfer, entered and left #1 after a clock edge; inputs are scrambled while busy.
    task automatic xfer(input int l, input logic m, input logic [W-1:0] w, input logic pb, input bit hold);
        exp_t e;
        int   d, x, k;
        d = div_of(l);
        x = xlen(l);
        start_v[l] = 1'b1;
        mode_v[l]  = m;
        pdin_v[l]  = w;
        @(posedge clk); #1;
        if (m == MODE_RX) mdl_pdout[l] = w;
        e.lane      = l;
        e.mode      = m;
        e.word      = w;
        e.pdout     = mdl_pdout[l];
        e.perr      = (PB == 1 && m == MODE_RX) ? (pb != ^w) : 1'b0;
        e.start_cyc = cyc;
        sb.push_back(e);
        for (int c = 1; c <= x; c++) begin
            k = (c - 1) / d;
            sdin_v[l]  = (m == MODE_RX) ? ((k < W) ? w[k] : pb) : 1'($urandom);
            start_v[l] = 1'($urandom);
            mode_v[l]  = 1'($urandom);
            pdin_v[l]  = W'($urandom);
            @(posedge clk); #1;
        end
        start_v[l] = hold ? 1'b1 : 1'($urandom);
        mode_v[l]  = 1'($urandom);
        pdin_v[l]  = W'($urandom);
        @(posedge clk); #1;
        start_v[l] = 1'b0;
    endtask

    task automatic abort_xfer(input int l, input logic [W-1:0] w);
        start_v[l] = 1'b1;
        mode_v[l]  = MODE_TX;
        pdin_v[l]  = w;
        @(posedge clk); #1;
        start_v[l] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        clr_v[l] = 1'b1;
        @(posedge clk); #1;
        clr_v[l] = 1'b0;
        mdl_pdout[l] = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] w;
        logic         m, pb;
        bit           hold;
        start_v = '0;
        mode_v  = '0;
        sdin_v  = '0;
        clr_v   = 2'b11;
        for (int l = 0; l < 2; l++) begin
            pdin_v[l]    = '0;
            mdl_pdout[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        clr_v = 2'b00;
        @(posedge clk); #1;

        xfer(0, MODE_TX, 8'hA5, 1'b0, 1'b0);
        xfer(1, MODE_RX, 8'h3C, 1'b0, 1'b0);
        abort_xfer(1, 8'h5A);
        xfer(1, MODE_TX, 8'hC3, 1'b0, 1'b0);
        abort_xfer(0, 8'hF0);
        xfer(0, MODE_RX, 8'h96, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++) begin
            xfer(l, MODE_TX, 8'h81, 1'b0, 1'b1);
            xfer(l, MODE_TX, 8'h7E, 1'b0, 1'b1);
            xfer(l, MODE_TX, 8'h55, 1'b0, 1'b0);
        end
`ifdef PARITY_EN
        xfer(1, MODE_RX, 8'h07, 1'b0, 1'b0);
        xfer(1, MODE_RX, 8'h07, 1'b1, 1'b0);
        xfer(0, MODE_TX, 8'h07, 1'b0, 1'b0);
`endif
        for (int l = 0; l < 2; l++) begin
            for (int n = 0; n < 12; n++) begin
                m    = 1'($urandom);
                w    = W'($urandom);
                pb   = 1'($urandom);
                hold = 1'($urandom);
                xfer(l, m, w, pb, hold);
                if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
